// File: rtl/stream_topk_pkg.sv
// Shared helpers for the streaming top-K tracker: compare rule, rank width
// derivation and the value that unoccupied slots hold.
package stream_topk_pkg;

   // Compares run at this width so one function serves any sample width up to 64 bits.
   localparam int MAXW = 65;

   localparam logic [MAXW-1:0] EMPTY_FILL = '0;

   function automatic int rank_w(input int k);
      return (k <= 2) ? 1 : $clog2(k);
   endfunction

   // The caller sign- or zero-extends the operands to MAXW before calling.
   function automatic logic ge(input logic [MAXW-1:0] a,
                               input logic [MAXW-1:0] b,
                               input logic            signed_mode);
      if (signed_mode)
         return $signed(a) >= $signed(b);
      else
         return a >= b;
   endfunction

endpackage

// File: rtl/stream_topk_slot.sv
// One rank of the sorted top-K list: holds its entry, decides whether the
// incoming sample belongs above it, and loads din or shifts in its left neighbour.
module stream_topk_slot
   import stream_topk_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear,
   input  logic             ins,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] left_e,
   input  logic             left_occ,
   input  logic             left_above,
   output logic [WIDTH-1:0] e,
   output logic             occ,
   output logic             above
);

   logic [WIDTH-1:0] e_reg;
   logic             occ_reg;
   logic [MAXW-1:0]  e_x;
   logic [MAXW-1:0]  din_x;

   assign e_x   = {{(MAXW-WIDTH){(SIGNED != 0) && e_reg[WIDTH-1]}}, e_reg};
   assign din_x = {{(MAXW-WIDTH){(SIGNED != 0) && din[WIDTH-1]}}, din};

   // An empty slot never blocks; a tie keeps the stored entry ahead of din.
   assign above = !occ_reg || !ge(e_x, din_x, SIGNED != 0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_reg   <= EMPTY_FILL[WIDTH-1:0];
         occ_reg <= 1'b0;
      end else if (clear) begin
         e_reg   <= EMPTY_FILL[WIDTH-1:0];
         occ_reg <= 1'b0;
      end else if (ins && above) begin
         if (left_above) begin
            e_reg   <= left_e;
            occ_reg <= left_occ;
         end else begin
            e_reg   <= din;
            occ_reg <= 1'b1;
         end
      end
   end

   assign e   = e_reg;
   assign occ = occ_reg;

endmodule

// File: rtl/stream_topk_tracker.sv
// Streaming tracker of the K largest samples since reset/clear, sorted
// descending, with a run-time rank select and a flat view of all entries.
module stream_topk_tracker
   import stream_topk_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int K      = 4,
   parameter int SIGNED = 0,
   parameter int UNIQUE = 0,
   parameter int RANK_W = rank_w(K)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               clear,
   input  logic               din_valid,
   input  logic [WIDTH-1:0]   din,
   input  logic [RANK_W-1:0]  rank_sel,
   output logic [WIDTH-1:0]   dout,
   output logic               dout_valid,
   output logic [RANK_W:0]    count,
   output logic               full,
   output logic [K*WIDTH-1:0] topk
);

   localparam logic [RANK_W:0] CNT_MAX = (RANK_W+1)'(K);

   logic [WIDTH-1:0] e_arr      [K];
   logic [WIDTH-1:0] left_e_arr [K];
   logic [K-1:0]     occ_arr;
   logic [K-1:0]     above_arr;
   logic [K-1:0]     left_occ_arr;
   logic [K-1:0]     left_above_arr;
   logic [RANK_W:0]  count_reg;
   logic             match;
   logic             ins;

   always_comb begin
      match = 1'b0;
      for (int i = 0; i < K; i++) begin
         if (occ_arr[i] && (e_arr[i] == din))
            match = 1'b1;
      end
   end

   assign ins = din_valid && !clear && !((UNIQUE != 0) && match);

   // Slot 0 has no left neighbour: it loads din whenever din goes above it.
   genvar gi;
   generate
      for (gi = 0; gi < K; gi++) begin : g_slot
         if (gi == 0) begin : g_head
            assign left_e_arr[gi]     = '0;
            assign left_occ_arr[gi]   = 1'b0;
            assign left_above_arr[gi] = 1'b0;
         end else begin : g_body
            assign left_e_arr[gi]     = e_arr[gi-1];
            assign left_occ_arr[gi]   = occ_arr[gi-1];
            assign left_above_arr[gi] = above_arr[gi-1];
         end

         stream_topk_slot #(
            .WIDTH  (WIDTH),
            .SIGNED (SIGNED)
         ) u_slot (
            .clk        (clk),
            .resetn     (resetn),
            .clear      (clear),
            .ins        (ins),
            .din        (din),
            .left_e     (left_e_arr[gi]),
            .left_occ   (left_occ_arr[gi]),
            .left_above (left_above_arr[gi]),
            .e          (e_arr[gi]),
            .occ        (occ_arr[gi]),
            .above      (above_arr[gi])
         );

         assign topk[gi*WIDTH +: WIDTH] = occ_arr[gi] ? e_arr[gi] : '0;
      end
   endgenerate

   // Any insertion reaches the last slot, so its decision says whether the list grows.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         count_reg <= '0;
      else if (clear)
         count_reg <= '0;
      else if (ins && above_arr[K-1] && (count_reg != CNT_MAX))
         count_reg <= count_reg + 1'b1;
   end

   assign count      = count_reg;
   assign full       = (count_reg == CNT_MAX);
   assign dout_valid = ({1'b0, rank_sel} < count_reg);

   always_comb begin
      dout = '0;
      for (int r = 0; r < K; r++) begin
         if (dout_valid && (rank_sel == r[RANK_W-1:0]))
            dout = e_arr[r];
      end
   end

endmodule

// File: tb/tb_stream_topk_tracker.sv
// Directed bench for stream_topk_tracker: four parameter variants share one
// stimulus bus; a table covers the basic stream, sequences cover the corners.
module tb_stream_topk_tracker;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        clear = 1'b0;
   logic        din_valid = 1'b0;
   logic [15:0] din = '0;
   logic [1:0]  rank_sel = '0;

   logic [15:0] a_dout, b_dout;
   logic [7:0]  c_dout, d_dout;
   logic        a_dv, b_dv, c_dv, d_dv;
   logic [2:0]  a_cnt, b_cnt, c_cnt, d_cnt;
   logic        a_full, b_full, c_full, d_full;
   logic [63:0] a_topk, b_topk;
   logic [31:0] c_topk, d_topk;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stream_topk_tracker #(.WIDTH(16), .K(4), .SIGNED(0), .UNIQUE(0)) u_a (
      .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
      .rank_sel(rank_sel), .dout(a_dout), .dout_valid(a_dv), .count(a_cnt),
      .full(a_full), .topk(a_topk));

   stream_topk_tracker #(.WIDTH(16), .K(4), .SIGNED(0), .UNIQUE(1)) u_b (
      .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
      .rank_sel(rank_sel), .dout(b_dout), .dout_valid(b_dv), .count(b_cnt),
      .full(b_full), .topk(b_topk));

   stream_topk_tracker #(.WIDTH(8), .K(4), .SIGNED(1), .UNIQUE(0)) u_c (
      .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din[7:0]),
      .rank_sel(rank_sel), .dout(c_dout), .dout_valid(c_dv), .count(c_cnt),
      .full(c_full), .topk(c_topk));

   stream_topk_tracker #(.WIDTH(8), .K(4), .SIGNED(0), .UNIQUE(0)) u_d (
      .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din[7:0]),
      .rank_sel(rank_sel), .dout(d_dout), .dout_valid(d_dv), .count(d_cnt),
      .full(d_full), .topk(d_topk));

   typedef struct {
      logic [15:0] din;
      logic [15:0] a_dout;
      logic        a_dv;
      logic [2:0]  a_cnt;
      logic [15:0] b_dout;
      logic        b_dv;
      logic [2:0]  b_cnt;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   task automatic feed(input logic v, input logic c, input logic [15:0] d);
      din_valid = v;
      clear     = c;
      din       = d;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      clear     = 1'b0;
   endtask

   // Occupied entries must stay non-increasing on every cycle.
   always @(negedge clk) begin
      if (resetn) begin
         for (int i = 1; i < 4; i++) begin
            if (i < int'(a_cnt)) begin
               n_cmp++;
               if (a_topk[(i-1)*16 +: 16] < a_topk[i*16 +: 16]) begin
                  n_bad++;
                  $display("FAIL order_a[%0d]: got %0h above %0h required non-increasing",
                           i, a_topk[(i-1)*16 +: 16], a_topk[i*16 +: 16]);
               end
            end
            if (i < int'(c_cnt)) begin
               n_cmp++;
               if ($signed(c_topk[(i-1)*8 +: 8]) < $signed(c_topk[i*8 +: 8])) begin
                  n_bad++;
                  $display("FAIL order_c[%0d]: got %0h above %0h required non-increasing",
                           i, c_topk[(i-1)*8 +: 8], c_topk[i*8 +: 8]);
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] exp_dv;
      logic [63:0] exp_dout;

      tbl[0] = '{16'd3,  16'd0,  1'b0, 3'd1, 16'd0,  1'b0, 3'd1};
      tbl[1] = '{16'd3,  16'd3,  1'b1, 3'd2, 16'd0,  1'b0, 3'd1};
      tbl[2] = '{16'd10, 16'd3,  1'b1, 3'd3, 16'd3,  1'b1, 3'd2};
      tbl[3] = '{16'd2,  16'd3,  1'b1, 3'd4, 16'd3,  1'b1, 3'd3};
      tbl[4] = '{16'd7,  16'd7,  1'b1, 3'd4, 16'd7,  1'b1, 3'd4};
      tbl[5] = '{16'd20, 16'd10, 1'b1, 3'd4, 16'd10, 1'b1, 3'd4};

      // reset state
      #1;
      chk("rst_count", 64'(a_cnt), 64'd0);
      chk("rst_topk", a_topk, 64'd0);
      chk("rst_full", 64'(a_full), 64'd0);
      chk("rst_dv", 64'(a_dv), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // stream 3,3,10,2,7,20 at rank 1, duplicates kept (a) and dropped (b)
      rank_sel = 2'd1;
      for (int i = 0; i < 6; i++) begin
         feed(1'b1, 1'b0, tbl[i].din);
         chk($sformatf("t1_dout[%0d]", i), 64'(a_dout), 64'(tbl[i].a_dout));
         chk($sformatf("t1_dv[%0d]", i),   64'(a_dv),   64'(tbl[i].a_dv));
         chk($sformatf("t1_cnt[%0d]", i),  64'(a_cnt),  64'(tbl[i].a_cnt));
         chk($sformatf("t2_dout[%0d]", i), 64'(b_dout), 64'(tbl[i].b_dout));
         chk($sformatf("t2_dv[%0d]", i),   64'(b_dv),   64'(tbl[i].b_dv));
         chk($sformatf("t2_cnt[%0d]", i),  64'(b_cnt),  64'(tbl[i].b_cnt));
      end
      chk("t1_topk", a_topk, 64'h0003_0007_000A_0014);
      chk("t1_full", 64'(a_full), 64'd1);
      chk("t2_topk", b_topk, 64'h0003_0007_000A_0014);

      // full array, sample below all entries, then a duplicate of rank 2
      feed(1'b1, 1'b0, 16'd1);
      chk("t4_low_topk", a_topk, 64'h0003_0007_000A_0014);
      chk("t4_low_cnt", 64'(a_cnt), 64'd4);
      feed(1'b1, 1'b0, 16'd7);
      chk("t4_dup_topk", a_topk, 64'h0007_0007_000A_0014);
      chk("t4_dup_cnt", 64'(a_cnt), 64'd4);
      chk("t4_uniq_topk", b_topk, 64'h0003_0007_000A_0014);

      // signed versus unsigned ordering on 8-bit samples
      feed(1'b0, 1'b1, 16'd0);
      rank_sel = 2'd0;
      feed(1'b1, 1'b0, 16'h00FB);
      feed(1'b1, 1'b0, 16'h0004);
      feed(1'b1, 1'b0, 16'h00FF);
      chk("t3_s_dout", 64'(c_dout), 64'h04);
      chk("t3_s_topk", 64'(c_topk), 64'h00FB_FF04);
      chk("t3_s_cnt", 64'(c_cnt), 64'd3);
      chk("t3_u_dout", 64'(d_dout), 64'hFF);
      chk("t3_u_topk", 64'(d_topk), 64'h0004_FBFF);

      // clear wins over a simultaneous sample
      feed(1'b0, 1'b1, 16'd0);
      feed(1'b1, 1'b0, 16'd1);
      feed(1'b1, 1'b0, 16'd2);
      feed(1'b1, 1'b0, 16'd3);
      feed(1'b1, 1'b1, 16'd50);
      chk("t5_cnt", 64'(a_cnt), 64'd0);
      chk("t5_topk", a_topk, 64'd0);
      chk("t5_dv", 64'(a_dv), 64'd0);
      feed(1'b1, 1'b0, 16'd5);
      chk("t5_next_topk", a_topk, 64'h0000_0000_0000_0005);
      chk("t5_next_cnt", 64'(a_cnt), 64'd1);

      // asynchronous reset between edges
      feed(1'b0, 1'b1, 16'd0);
      feed(1'b1, 1'b0, 16'd1);
      feed(1'b1, 1'b0, 16'd2);
      feed(1'b1, 1'b0, 16'd3);
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_async_cnt", 64'(a_cnt), 64'd0);
      chk("t6_async_topk", a_topk, 64'd0);
      chk("t6_async_dv", 64'(a_dv), 64'd0);
      chk("t6_async_dout", 64'(a_dout), 64'd0);
      chk("t6_async_full", 64'(a_full), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      feed(1'b1, 1'b0, 16'd9);
      feed(1'b1, 1'b0, 16'd4);
      chk("t6_topk", a_topk, 64'h0000_0000_0004_0009);
      chk("t6_cnt", 64'(a_cnt), 64'd2);
      exp_dv   = 4'b0011;
      exp_dout = 64'h0000_0000_0004_0009;
      for (int r = 0; r < 4; r++) begin
         rank_sel = 2'(r);
         #1;
         chk($sformatf("t6_dv[%0d]", r), 64'(a_dv), 64'(exp_dv[r]));
         chk($sformatf("t6_dout[%0d]", r), 64'(a_dout), 64'(exp_dout[r*16 +: 16]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
